// File: rtl/rfrac_conv18_16_stg2.sv
// rtl/rfrac_conv18_16_stg2.sv - MRC stage 2: D3 = A3, A_j' = ((A_j - A3) mod M_j) * M3^-1 mod M_j.
// Optional residue range checking is built when RFRAC_RES_CHK_EN is defined.
module rfrac_conv18_16_stg2 #(
   parameter int M3   = 78125,
   parameter int M4   = 131072,
   parameter int M5   = 177147,
   parameter int M6   = 117649,
   parameter int INV4 = 83621,
   parameter int INV5 = 159896,
   parameter int INV6 = 22816
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [17:0] mr_A3_in,
   input  logic [17:0] mr_A4_in,
   input  logic [17:0] mr_A5_in,
   input  logic [17:0] mr_A6_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [17:0] mr_A4_out,
   output logic [17:0] mr_A5_out,
   output logic [17:0] mr_A6_out,
   output logic [17:0] mr_D3_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err_out,
   output logic        err_sticky
);

   if (M4 < M3 || M5 < M3 || M6 < M3 ||
       M4 >= (1 << 18) || M5 >= (1 << 18) || M6 >= (1 << 18)) begin : g_bad_modulus
      $error("rfrac_conv18_16_stg2: lane modulus out of range");
   end

   localparam logic [2:0][17:0] MJ   = {18'(M6), 18'(M5), 18'(M4)};
   localparam logic [2:0][17:0] INVJ = {18'(INV6), 18'(INV5), 18'(INV4)};

   logic [2:0][17:0] a_in;
   logic             ce;
   logic             err_in;

   logic [3:0]       v_q, v_d;
   logic [3:0]       err_q, err_d;
   logic [3:0][17:0] a3_q, a3_d;
   logic [2:0][17:0] dif_q, dif_d;
   logic [2:0][35:0] prod_q, prod_d;
   logic [2:0][35:0] prod3_q, prod3_d;
   logic [2:0][17:0] quo_q, quo_d;
   logic [2:0][17:0] res_q, res_d;
   logic             sticky_q, sticky_d;

   assign a_in = {mr_A6_in, mr_A5_in, mr_A4_in};
   assign ce   = !v_q[3] || out_ready;

   always_comb begin
      err_in = 1'b0;
`ifdef RFRAC_RES_CHK_EN
      err_in = (mr_A3_in >= 18'(M3));
      for (int j = 0; j < 3; j++) begin
         if (a_in[j] >= MJ[j]) err_in = 1'b1;
      end
`endif
   end

   always_comb begin
      v_d      = v_q;
      err_d    = err_q;
      a3_d     = a3_q;
      dif_d    = dif_q;
      prod_d   = prod_q;
      prod3_d  = prod3_q;
      quo_d    = quo_q;
      res_d    = res_q;
      sticky_d = sticky_q || (v_q[3] && err_q[3]);
      if (ce) begin
         v_d   = {v_q[2:0], in_valid};
         err_d = {err_q[2:0], err_in};
         a3_d  = {a3_q[2:0], mr_A3_in};
         for (int j = 0; j < 3; j++) begin
            // Wrap branch relies on 18-bit modular arithmetic; the true result is < M_j.
            if (a_in[j] >= mr_A3_in) dif_d[j] = a_in[j] - mr_A3_in;
            else                     dif_d[j] = a_in[j] + MJ[j] - mr_A3_in;
            prod_d[j]  = 36'(dif_q[j]) * 36'(INVJ[j]);
            // Quotient is below INV_j for legal inputs, so it fits in 18 bits.
            quo_d[j]   = 18'(prod_q[j] / 36'(MJ[j]));
            prod3_d[j] = prod_q[j];
            res_d[j]   = 18'(prod3_q[j] - 36'(quo_q[j]) * 36'(MJ[j]));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q      <= '0;
         err_q    <= '0;
         a3_q     <= '0;
         dif_q    <= '0;
         prod_q   <= '0;
         prod3_q  <= '0;
         quo_q    <= '0;
         res_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         v_q      <= v_d;
         err_q    <= err_d;
         a3_q     <= a3_d;
         dif_q    <= dif_d;
         prod_q   <= prod_d;
         prod3_q  <= prod3_d;
         quo_q    <= quo_d;
         res_q    <= res_d;
         sticky_q <= sticky_d;
      end
   end

   assign in_ready   = ce;
   assign out_valid  = v_q[3];
   assign mr_A4_out  = res_q[0];
   assign mr_A5_out  = res_q[1];
   assign mr_A6_out  = res_q[2];
   assign mr_D3_out  = a3_q[3];
   assign err_out    = err_q[3];
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_rfrac_conv18_16_stg2.sv
// tb/tb_rfrac_conv18_16_stg2.sv - self-checking bench for rfrac_conv18_16_stg2.
// Range-error scenarios are compiled when RFRAC_RES_CHK_EN is defined.
module tb_rfrac_conv18_16_stg2;

   localparam longint M3 = 78125, M4 = 131072, M5 = 177147, M6 = 117649;
   localparam longint INV4 = 83621, INV5 = 159896, INV6 = 22816;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [17:0] mr_A3_in = '0, mr_A4_in = '0, mr_A5_in = '0, mr_A6_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] mr_A4_out, mr_A5_out, mr_A6_out, mr_D3_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        err_out, err_sticky;

   typedef struct {
      logic [17:0] a4, a5, a6, d3;
      logic        err;
      int          cyc;
   } word_t;

   word_t exp_q[$];
   word_t got_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;

   rfrac_conv18_16_stg2 dut (
      .clk(clk), .reset(reset),
      .mr_A3_in(mr_A3_in), .mr_A4_in(mr_A4_in), .mr_A5_in(mr_A5_in), .mr_A6_in(mr_A6_in),
      .in_valid(in_valid), .in_ready(in_ready),
      .mr_A4_out(mr_A4_out), .mr_A5_out(mr_A5_out), .mr_A6_out(mr_A6_out),
      .mr_D3_out(mr_D3_out), .out_valid(out_valid), .out_ready(out_ready),
      .err_out(err_out), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   // Software MRC step: (A_j - A3) reduced mod M_j, then scaled by M3^-1 mod M_j.
   function automatic logic [17:0] mrc(input longint a3, input longint aj,
                                       input longint m, input longint inv);
      longint d;
      d = (aj - a3) % m;
      if (d < 0) d = d + m;
      return 18'((d * inv) % m);
   endfunction

   function automatic word_t model(input logic [17:0] a3, a4, a5, a6);
      word_t w;
      w.a4  = mrc(a3, a4, M4, INV4);
      w.a5  = mrc(a3, a5, M5, INV5);
      w.a6  = mrc(a3, a6, M6, INV6);
      w.d3  = a3;
      w.err = 1'b0;
`ifdef RFRAC_RES_CHK_EN
      w.err = (a3 >= M3) || (a4 >= M4) || (a5 >= M5) || (a6 >= M6);
`endif
      w.cyc = 0;
      return w;
   endfunction

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         if (in_valid && in_ready) exp_q.push_back(model(mr_A3_in, mr_A4_in, mr_A5_in, mr_A6_in));
         if (out_valid && out_ready)
            got_q.push_back('{mr_A4_out, mr_A5_out, mr_A6_out, mr_D3_out, err_out, cyc});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic [17:0] a3, a4, a5, a6);
      in_valid  = v;
      out_ready = r;
      mr_A3_in  = a3;
      mr_A4_in  = a4;
      mr_A5_in  = a5;
      mr_A6_in  = a6;
   endtask

   task automatic drive_rand(input logic v, input logic r);
      drive(v, r, 18'($urandom_range(int'(M3) - 1, 0)), 18'($urandom_range(int'(M4) - 1, 0)),
            18'($urandom_range(int'(M5) - 1, 0)), 18'($urandom_range(int'(M6) - 1, 0)));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_rand(1'b1, 1'b1);
      repeat (3) tick();
      total += 8;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      if (mr_A4_out !== 18'd0) begin bad++; $display("FAIL reset_a4 got=%0d want=0", mr_A4_out); end
      if (mr_A5_out !== 18'd0) begin bad++; $display("FAIL reset_a5 got=%0d want=0", mr_A5_out); end
      if (mr_A6_out !== 18'd0) begin bad++; $display("FAIL reset_a6 got=%0d want=0", mr_A6_out); end
      if (mr_D3_out !== 18'd0) begin bad++; $display("FAIL reset_d3 got=%0d want=0", mr_D3_out); end
      if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err_out); end
      if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%0b want=0", err_sticky); end
      drive(1'b0, 1'b0, '0, '0, '0, '0);
      #1;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [17:0] vin [3][4];
      logic [17:0] vout[3][4];
      int lat;
      vin[0]  = '{18'd0, 18'd1, 18'd1, 18'd1};
      vout[0] = '{18'd0, 18'd83621, 18'd159896, 18'd22816};
      vin[1]  = '{18'd1, 18'd0, 18'd0, 18'd0};
      vout[1] = '{18'd1, 18'd47451, 18'd17251, 18'd94833};
      vin[2]  = '{18'd5, 18'd5, 18'd5, 18'd5};
      vout[2] = '{18'd5, 18'd0, 18'd0, 18'd0};
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, vin[k][0], vin[k][1], vin[k][2], vin[k][3]);
         tick();
         drive(1'b0, 1'b1, '0, '0, '0, '0);
         lat = 1;
         while (!out_valid && lat < 12) begin tick(); lat++; end
         total += 5;
         if (lat !== 4) begin bad++; $display("FAIL dir%0d_latency got=%0d want=4", k, lat); end
         if (mr_D3_out !== vout[k][0]) begin bad++; $display("FAIL dir%0d_d3 got=%0d want=%0d", k, mr_D3_out, vout[k][0]); end
         if (mr_A4_out !== vout[k][1]) begin bad++; $display("FAIL dir%0d_a4 got=%0d want=%0d", k, mr_A4_out, vout[k][1]); end
         if (mr_A5_out !== vout[k][2]) begin bad++; $display("FAIL dir%0d_a5 got=%0d want=%0d", k, mr_A5_out, vout[k][2]); end
         if (mr_A6_out !== vout[k][3]) begin bad++; $display("FAIL dir%0d_a6 got=%0d want=%0d", k, mr_A6_out, vout[k][3]); end
         repeat (2) tick();
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 20; i++) begin
         drive_rand(1'b1, 1'b1);
         tick();
      end
      drive(1'b0, 1'b1, '0, '0, '0, '0);
      repeat (8) tick();
      total++;
      if (got_q.size() !== 20) begin bad++; $display("FAIL b2b_count got=%0d want=20", got_q.size()); end
      for (int i = 0; i < 20 && i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i].a4 !== exp_q[i].a4 || got_q[i].a5 !== exp_q[i].a5 || got_q[i].a6 !== exp_q[i].a6 ||
             got_q[i].d3 !== exp_q[i].d3 || got_q[i].err !== exp_q[i].err) begin
            bad++;
            $display("FAIL b2b_word%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                     got_q[i].a4, got_q[i].a5, got_q[i].a6, got_q[i].d3,
                     exp_q[i].a4, exp_q[i].a5, exp_q[i].a6, exp_q[i].d3);
         end
         if (i > 0) begin
            total++;
            if (got_q[i].cyc !== got_q[i-1].cyc + 1) begin
               bad++;
               $display("FAIL b2b_spacing%0d got=%0d want=1", i, got_q[i].cyc - got_q[i-1].cyc);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [17:0] snap[4];
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 30; i++) begin
         if (i >= 7 && i <= 12) begin
            total++;
            if (mr_A4_out !== snap[0] || mr_A5_out !== snap[1] || mr_A6_out !== snap[2] ||
                mr_D3_out !== snap[3] || out_valid !== 1'b1) begin
               bad++;
               $display("FAIL stall_frozen%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                        mr_A4_out, mr_A5_out, mr_A6_out, mr_D3_out, snap[0], snap[1], snap[2], snap[3]);
            end
         end
         drive_rand(i < 14, !(i >= 6 && i < 12));
         #1;
         if (i == 6) snap = '{mr_A4_out, mr_A5_out, mr_A6_out, mr_D3_out};
         if (i >= 6 && i < 12) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d got=%0b want=0", i, in_ready); end
         end
         tick();
      end
      total += 2;
      if (exp_q.size() !== 8) begin bad++; $display("FAIL stall_accepted got=%0d want=8", exp_q.size()); end
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i].a4 !== exp_q[i].a4 || got_q[i].a5 !== exp_q[i].a5 ||
             got_q[i].a6 !== exp_q[i].a6 || got_q[i].d3 !== exp_q[i].d3) begin
            bad++;
            $display("FAIL stall_word%0d got=%0d/%0d want=%0d/%0d", i,
                     got_q[i].a4, got_q[i].d3, exp_q[i].a4, exp_q[i].d3);
         end
      end
   endtask

`ifdef RFRAC_RES_CHK_EN
   task automatic test_err();
      exp_q.delete();
      got_q.delete();
      drive_rand(1'b1, 1'b1);
      tick();
      drive(1'b1, 1'b1, 18'd7, 18'd131072, 18'd3, 18'd4);
      tick();
      drive_rand(1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b1, '0, '0, '0, '0);
      repeat (8) tick();
      total += 2;
      if (got_q.size() !== 3) begin bad++; $display("FAIL err_count got=%0d want=3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         total++;
         if (got_q[i].err !== exp_q[i].err) begin
            bad++;
            $display("FAIL err_flag%0d got=%0b want=%0b", i, got_q[i].err, exp_q[i].err);
         end
         if (!exp_q[i].err) begin
            total++;
            if (got_q[i].a4 !== exp_q[i].a4 || got_q[i].d3 !== exp_q[i].d3) begin
               bad++;
               $display("FAIL err_data%0d got=%0d want=%0d", i, got_q[i].a4, exp_q[i].a4);
            end
         end
      end
      if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", err_sticky); end
   endtask
`endif

   task automatic test_reset_in_stall();
      for (int i = 0; i < 6; i++) begin
         drive_rand(1'b1, 1'b0);
         tick();
      end
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_stall_prefill got=%0b want=1", out_valid); end
      reset = 1'b1;
      tick();
      total += 5;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_out_valid got=%0b want=0", out_valid); end
      if (err_sticky !== 1'b0) begin bad++; $display("FAIL rst_stall_sticky got=%0b want=0", err_sticky); end
      if (mr_A4_out !== 18'd0) begin bad++; $display("FAIL rst_stall_a4 got=%0d want=0", mr_A4_out); end
      if (mr_D3_out !== 18'd0) begin bad++; $display("FAIL rst_stall_d3 got=%0d want=0", mr_D3_out); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_stall_in_ready got=%0b want=1", in_ready); end
      drive(1'b0, 1'b1, '0, '0, '0, '0);
      reset = 1'b0;
      repeat (6) tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_no_ghost got=%0b want=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
`ifdef RFRAC_RES_CHK_EN
      test_err();
`endif
      test_reset_in_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
